// File: rtl/button_counter_pkg.sv
// Shared constants for the push-button BCD counter: active-low 7-segment glyphs
// and the role assigned to each button input.
package button_counter_pkg;

    // Segment order {dp,g,f,e,d,c,b,a}, active-low, decimal point off.
    localparam logic [7:0] GLYPH_0     = 8'hC0;
    localparam logic [7:0] GLYPH_1     = 8'hF9;
    localparam logic [7:0] GLYPH_2     = 8'hA4;
    localparam logic [7:0] GLYPH_3     = 8'hB0;
    localparam logic [7:0] GLYPH_4     = 8'h99;
    localparam logic [7:0] GLYPH_5     = 8'h92;
    localparam logic [7:0] GLYPH_6     = 8'h82;
    localparam logic [7:0] GLYPH_7     = 8'hF8;
    localparam logic [7:0] GLYPH_8     = 8'h80;
    localparam logic [7:0] GLYPH_9     = 8'h90;
    localparam logic [7:0] GLYPH_BLANK = 8'hFF;

    localparam int BTN_INC   = 0;
    localparam int BTN_DEC   = 1;
    localparam int BTN_CLR   = 2;
    localparam int BTN_BLANK = 3;

    // Non-decimal codes cannot be produced by the counter; show them dark.
    function automatic logic [7:0] glyph_of(input logic [3:0] digit);
        logic [7:0] g;
        case (digit)
            4'd0:    g = GLYPH_0;
            4'd1:    g = GLYPH_1;
            4'd2:    g = GLYPH_2;
            4'd3:    g = GLYPH_3;
            4'd4:    g = GLYPH_4;
            4'd5:    g = GLYPH_5;
            4'd6:    g = GLYPH_6;
            4'd7:    g = GLYPH_7;
            4'd8:    g = GLYPH_8;
            4'd9:    g = GLYPH_9;
            default: g = GLYPH_BLANK;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/button_counter_debounce.sv
// One button: two-flop synchronizer, stability counter, debounced level and a
// single-cycle pulse on each accepted press.
module button_debounce
    import button_counter_pkg::*;
#(
    parameter int DEBOUNCE_BITS = 18
) (
    input  logic clk,
    input  logic rst,
    input  logic button,
    output logic pressed,
    output logic press
);

    logic [1:0]               sync_r;
    logic [DEBOUNCE_BITS-1:0] cnt_r;
    logic                     pressed_r;
    logic                     pressed_d_r;
    logic                     press_r;

    // Synchronize, qualify the new level over the full interval, edge-detect presses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_r      <= 2'b00;
            cnt_r       <= '0;
            pressed_r   <= 1'b0;
            pressed_d_r <= 1'b0;
            press_r     <= 1'b0;
        end else begin
            // Pin is active-low; invert at the first flop so everything after is active-high.
            sync_r <= {sync_r[0], ~button};
            if (sync_r[1] == pressed_r) begin
                cnt_r <= '0;
            end else if (&cnt_r) begin
                pressed_r <= sync_r[1];
                cnt_r     <= '0;
            end else begin
                cnt_r <= cnt_r + DEBOUNCE_BITS'(1);
            end
            pressed_d_r <= pressed_r;
            press_r     <= pressed_r & ~pressed_d_r;
        end
    end

    assign pressed = pressed_r;
    assign press   = press_r;

endmodule

// File: rtl/button_counter.sv
// Debounced buttons drive a wrapping BCD counter whose digits are presented as
// registered active-low 7-segment patterns, with a toggleable blank.
module button_counter
    import button_counter_pkg::*;
#(
    parameter int NUM_DIGITS    = 3,
    parameter int NUM_SEGS      = 8,
    parameter int NUM_BUTTONS   = 4,
    parameter int DEBOUNCE_BITS = 18
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_BUTTONS-1:0]         BUTTON,
    output logic [NUM_BUTTONS-1:0]         PRESSED,
    output logic [NUM_BUTTONS-1:0]         PRESS,
    output logic [4*NUM_DIGITS-1:0]        VALUE,
    output logic [NUM_SEGS*NUM_DIGITS-1:0] SEGS
);

    logic [NUM_BUTTONS-1:0]         pressed_s;
    logic [NUM_BUTTONS-1:0]         press_s;
    logic [4*NUM_DIGITS-1:0]        value_r;
    logic [4*NUM_DIGITS-1:0]        value_next_s;
    logic                           blank_r;
    logic                           blank_next_s;
    logic [NUM_SEGS*NUM_DIGITS-1:0] segs_r;
    logic [NUM_SEGS*NUM_DIGITS-1:0] segs_next_s;
    logic                           inc_s;
    logic                           dec_s;

    for (genvar b = 0; b < NUM_BUTTONS; b++) begin : g_btn
        button_debounce #(
            .DEBOUNCE_BITS(DEBOUNCE_BITS)
        ) u_debounce (
            .clk    (clk),
            .rst    (rst),
            .button (BUTTON[b]),
            .pressed(pressed_s[b]),
            .press  (press_s[b])
        );
    end

    // Digit-serial carry/borrow ripple; a digit changes only while the chain is live.
    function automatic logic [4*NUM_DIGITS-1:0] bcd_step(
        input logic [4*NUM_DIGITS-1:0] v,
        input logic                    up
    );
        logic [4*NUM_DIGITS-1:0] r;
        logic [3:0]              d;
        logic                    chain;
        r     = v;
        chain = 1'b1;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            d = v[4*k +: 4];
            if (chain) begin
                if (up) begin
                    if (d >= 4'd9) begin
                        d     = 4'd0;
                        chain = 1'b1;
                    end else begin
                        d     = d + 4'd1;
                        chain = 1'b0;
                    end
                end else begin
                    if (d == 4'd0) begin
                        d     = 4'd9;
                        chain = 1'b1;
                    end else begin
                        d     = d - 4'd1;
                        chain = 1'b0;
                    end
                end
            end else begin
                chain = 1'b0;
            end
            r[4*k +: 4] = d;
        end
        return r;
    endfunction

    assign inc_s = press_s[BTN_INC];
    assign dec_s = press_s[BTN_DEC];

    // Next counter value: clear wins, simultaneous inc+dec cancel.
    always_comb begin
        value_next_s = value_r;
        blank_next_s = blank_r ^ press_s[BTN_BLANK];
        if (press_s[BTN_CLR]) begin
            value_next_s = '0;
        end else if (inc_s && !dec_s) begin
            value_next_s = bcd_step(value_r, 1'b1);
        end else if (dec_s && !inc_s) begin
            value_next_s = bcd_step(value_r, 1'b0);
        end else begin
            value_next_s = value_r;
        end
    end

    // Segment patterns for the current value, or all dark when blanked.
    always_comb begin
        segs_next_s = '1;
        if (blank_r) begin
            segs_next_s = '1;
        end else begin
            for (int k = 0; k < NUM_DIGITS; k++) begin
                segs_next_s[NUM_SEGS*k +: NUM_SEGS] = NUM_SEGS'(glyph_of(value_r[4*k +: 4]));
            end
        end
    end

    // Counter, blank flag and display registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value_r <= '0;
            blank_r <= 1'b0;
            segs_r  <= {NUM_DIGITS{NUM_SEGS'(GLYPH_0)}};
        end else begin
            value_r <= value_next_s;
            blank_r <= blank_next_s;
            segs_r  <= segs_next_s;
        end
    end

    assign PRESSED = pressed_s;
    assign PRESS   = press_s;
    assign VALUE   = value_r;
    assign SEGS    = segs_r;

endmodule

// File: tb/tb_button_counter.sv
// Directed and randomized button sequences against an integer-valued model of
// the counter, blank flag and expected press pulses.
module tb_button_counter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  BUTTON;
    logic [3:0]  PRESSED;
    logic [3:0]  PRESS;
    logic [11:0] VALUE;
    logic [23:0] SEGS;

    button_counter #(
        .NUM_DIGITS   (3),
        .NUM_SEGS     (8),
        .NUM_BUTTONS  (4),
        .DEBOUNCE_BITS(4)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .BUTTON (BUTTON),
        .PRESSED(PRESSED),
        .PRESS  (PRESS),
        .VALUE  (VALUE),
        .SEGS   (SEGS)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;
    int pcnt[4]  = '{0, 0, 0, 0};
    int exp_p[4] = '{0, 0, 0, 0};
    int model_v  = 0;
    bit model_blank = 1'b0;
    logic [7:0] gl[10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                           8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

    // PRESS sampled before the edge updates it: every high cycle is counted once.
    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (PRESS[i]) pcnt[i] <= pcnt[i] + 1;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [11:0] to_bcd(input int v);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic logic [23:0] exp_segs(input int v, input bit b);
        if (b) return 24'hFFFFFF;
        return {gl[v / 100], gl[(v / 10) % 10], gl[v % 10]};
    endfunction

    task automatic check_all(input string tag);
        check({tag, "_value"}, 32'(VALUE), 32'(to_bcd(model_v)));
        check({tag, "_segs"}, 32'(SEGS), 32'(exp_segs(model_v, model_blank)));
        check({tag, "_pressed"}, 32'(PRESSED), 32'h0);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("%s_npress%0d", tag, i), 32'(pcnt[i]), 32'(exp_p[i]));
        end
    endtask

    // Hold the masked buttons together, release, let everything settle, then check.
    task automatic do_press(input logic [3:0] mask, input int hold, input int gap, input string tag);
        BUTTON = ~mask;
        tick(hold);
        BUTTON = 4'hF;
        tick(gap);
        for (int i = 0; i < 4; i++) begin
            if (mask[i]) exp_p[i]++;
        end
        if (mask[2]) model_v = 0;
        else if (mask[0] && !mask[1]) model_v = (model_v + 1) % 1000;
        else if (mask[1] && !mask[0]) model_v = (model_v + 999) % 1000;
        if (mask[3]) model_blank = !model_blank;
        check_all(tag);
    endtask

    initial begin
        logic [3:0] m;
        rst    = 1'b1;
        BUTTON = 4'hF;
        tick(3);
        rst = 1'b0;
        tick(2);
        check("reset_value", 32'(VALUE), 32'h000);
        check("reset_segs", 32'(SEGS), 32'hC0C0C0);
        check("reset_press", 32'(PRESS), 32'h0);
        check("reset_pressed", 32'(PRESSED), 32'h0);

        // Glitch shorter than the qualification interval.
        BUTTON = 4'hE;
        tick(10);
        BUTTON = 4'hF;
        tick(30);
        check_all("glitch");

        for (int k = 0; k < 12; k++) do_press(4'b0001, 40, 30, "inc12");
        check("inc12_final", 32'(VALUE), 32'h012);
        check("inc12_segs", 32'(SEGS), 32'hC0F9A4);

        do_press(4'b0100, 40, 30, "clr");
        do_press(4'b0010, 40, 30, "dec_wrap");
        check("dec_wrap_segs", 32'(SEGS), 32'h909090);
        do_press(4'b0001, 40, 30, "inc_wrap");
        check("inc_wrap_value", 32'(VALUE), 32'h000);

        for (int k = 0; k < 5; k++) do_press(4'b0001, 30, 30, "to5");
        do_press(4'b0101, 40, 30, "inc_clr");
        check("inc_clr_value", 32'(VALUE), 32'h000);
        for (int k = 0; k < 3; k++) do_press(4'b0001, 30, 30, "to3");
        do_press(4'b0011, 40, 30, "inc_dec");
        check("inc_dec_value", 32'(VALUE), 32'h003);

        do_press(4'b1000, 40, 30, "blank_on");
        check("blank_segs", 32'(SEGS), 32'hFFFFFF);
        do_press(4'b0001, 40, 30, "inc_blanked");
        do_press(4'b1000, 40, 30, "blank_off");

        // Randomized combinations of buttons and hold/gap lengths.
        for (int k = 0; k < 24; k++) begin
            m = 4'($urandom_range(1, 15));
            do_press(m, $urandom_range(25, 45), $urandom_range(25, 45), $sformatf("rnd%0d", k));
        end

        // Reset partway into debouncing a held button: it must re-qualify from scratch.
        BUTTON = 4'hE;
        tick(8);
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        model_v     = 0;
        model_blank = 1'b0;
        check("rst_mid_value", 32'(VALUE), 32'h000);
        for (int k = 0; k < 16; k++) begin
            tick(1);
            check($sformatf("rst_mid_pressed_c%0d", k), 32'(PRESSED[0]), 32'h0);
            check($sformatf("rst_mid_press_c%0d", k), 32'(PRESS[0]), 32'h0);
        end
        tick(4);
        check("rst_requal_pressed", 32'(PRESSED[0]), 32'h1);
        BUTTON = 4'hF;
        tick(30);
        exp_p[0]++;
        model_v = 1;
        check_all("rst_requal");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/button_counter.md
# button_counter

Debounces the board push-buttons and maintains a NUM_DIGITS-digit decimal counter they control, presenting registered 7-segment patterns per digit. Sits between the raw BUTTON pins and the digit-multiplexing display driver, supplying its per-digit segment vectors (segs0..segs2). Also exports debounced levels and one-cycle press pulses for other consumers.

## Interface

- NUM_DIGITS, 3, number of decimal digits counted and encoded
- NUM_SEGS, 8, segment bits per digit; order {dp,g,f,e,d,c,b,a}
- NUM_BUTTONS, 4, number of button inputs
- DEBOUNCE_BITS, 18, width of the debounce counter; a new level is accepted after 2^DEBOUNCE_BITS stable cycles (5.24 ms at 50 MHz)

- clk  in  1  system clock (OSC_50M)
- rst  in  1  asynchronous, active-high reset
- BUTTON  in  NUM_BUTTONS  raw button pins, active-low (0 = pressed), asynchronous to clk
- PRESSED  out  NUM_BUTTONS  debounced level, active-high
- PRESS  out  NUM_BUTTONS  one-cycle pulse on each debounced press
- VALUE  out  4*NUM_DIGITS  counter, packed BCD, digit 0 in [3:0]
- SEGS  out  NUM_SEGS*NUM_DIGITS  segment patterns, active-low, digit 0 in [NUM_SEGS-1:0]

## Operation

- Per button: 2-flop synchronizer (inverted to active-high), then debounce counter. If synced level equals PRESSED[i], counter clears. Otherwise counter increments; on the cycle it is all-ones, PRESSED[i] takes the synced level and counter clears.
- PRESS[i] high for exactly one cycle after PRESSED[i] rises; releases produce no pulse.
- Button functions: 0 = increment, 1 = decrement, 2 = clear, 3 = toggle blank.
- Priority per cycle: clear > (inc and dec together = no change) > inc/dec.
- Increment wraps 999 -> 000; decrement wraps 000 -> 999; per-digit BCD carry/borrow, no binary intermediate.
- Glyphs (active-low, dp off): 0 C0, 1 F9, 2 A4, 3 B0, 4 99, 5 92, 6 82, 7 F8, 8 80, 9 90. Codes A-F unreachable; encode as FF.
- Blank set: every SEGS bit 1. Counter keeps operating while blanked.

## Timing

- Reset values: sync flops and PRESSED all 0, debounce counters 0, PRESS 0, VALUE 0, blank 0, SEGS = C0 per digit.
- Press latency: BUTTON edge -> 2 sync cycles -> 2^DEBOUNCE_BITS stable cycles -> PRESSED rises -> PRESS the next cycle.
- VALUE and blank update on the edge at which PRESS is high (visible 1 cycle after PRESS). SEGS registered from VALUE/blank, 1 further cycle.
- A glitch shorter than 2^DEBOUNCE_BITS cycles restarts the counter; no PRESS.
- A held button yields one PRESS (no auto-repeat).
- rst mid-debounce: counter and PRESSED clear immediately; a still-held button must re-qualify the full interval before pressing.

## Structure

- Package button_counter_pkg: glyph constants GLYPH_0..GLYPH_9, GLYPH_BLANK, button index constants BTN_INC, BTN_DEC, BTN_CLR, BTN_BLANK.
- Sub-module button_debounce (one button: synchronizer, counter, level, press pulse), instanced NUM_BUTTONS times. Counter/encoder logic in the top.

## Test plan

Use DEBOUNCE_BITS = 4 (16 cycles).

- Assert then release rst, buttons released -> VALUE 0x000, SEGS 0xC0C0C0, PRESS 0.
- BUTTON[0] low for 10 cycles, then high -> no PRESS, VALUE stays 0x000.
- Twelve clean presses on BUTTON[0] (each held 40 cycles) -> VALUE 0x012, SEGS 0xC0F9A4, exactly twelve PRESS[0] pulses.
- From 0x000, one press on BUTTON[1] -> VALUE 0x999, SEGS 0x909090; then one press on BUTTON[0] -> 0x000.
- BUTTON[0] and BUTTON[2] pressed on the same cycle from 0x005 -> VALUE 0x000. BUTTON[0] and BUTTON[1] together -> VALUE unchanged.
- Press BUTTON[3] -> SEGS 0xFFFFFF, VALUE unchanged. Assert rst while BUTTON[0] is held 8 cycles into debounce -> PRESSED 0, no PRESS until 16+ cycles after rst release.
